hrm_io_ctrl: RTL and testbench

HRM_IO_CTRL -- requirements
Module: hrm_io_ctrl

---
 rtl/hrm_io_pkg.sv | 17 +
 rtl/rr_arb2.sv | 28 ++
 rtl/hrm_io_ctrl.sv | 140 ++++++++++++++
 tb/tb_hrm_io_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hrm_io_pkg.sv
// Shared definitions for the HRM I/O controller: default byte width and FSM encodings.
package hrm_io_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_WR   = 1'b1
    } in_state_t;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_HOLD = 2'd1,
        O_GAP  = 2'd2
    } out_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is requester A, bit 1 is requester B.
module rr_arb2 (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_last_b;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last_b ? 2'b01 : 2'b10;
        end
    end

    // Out of reset B counts as last winner, so A takes the first contested grant.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_last_b <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            r_last_b <= grant[1];
        end
    end

endmodule

// File: rtl/hrm_io_ctrl.sv
// CPU mailbox glue: arbitrated INBOX writer, single-byte OUTBOX drainer and single-step pulse logic.
module hrm_io_ctrl
    import hrm_io_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic          a_valid,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic [DW-1:0] cpu_in_data,
    output logic          cpu_in_wr,
    input  logic          cpu_in_full,
    input  logic [DW-1:0] cpu_out_data,
    input  logic          cpu_out_empty,
    output logic          cpu_out_rd,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          o_ready,
    input  logic          step_mode,
    input  logic          step_req,
    output logic          cpu_debug,
    output logic          cpu_nxtInstr
);

    in_state_t     r_in_state;
    logic          r_run;
    logic          r_in_wr;
    logic [DW-1:0] r_in_data;
    logic          w_in_open;
    logic [1:0]    w_req;
    logic [1:0]    w_grant;

    out_state_t    r_o_state;
    logic          r_o_valid;
    logic [DW-1:0] r_o_data;
    logic          r_out_rd;

    logic          r_debug;
    logic          r_req_d1;
    logic          r_req_d2;
    logic          r_nxt;
    logic          w_step_edge;

    // r_run keeps readies low while in reset and for the first cycle after release.
    assign w_in_open = r_run && (r_in_state == IN_IDLE) && !cpu_in_full;
    assign w_req     = {b_valid, a_valid} & {2{w_in_open}};

    rr_arb2 u_arb (
        .clk     (clk),
        .i_rst   (i_rst),
        .req     (w_req),
        .advance (w_in_open),
        .grant   (w_grant)
    );

    assign a_ready     = w_grant[0];
    assign b_ready     = w_grant[1];
    assign cpu_in_wr   = r_in_wr;
    assign cpu_in_data = r_in_data;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_run      <= 1'b0;
            r_in_state <= IN_IDLE;
            r_in_wr    <= 1'b0;
            r_in_data  <= '0;
        end else begin
            r_run   <= 1'b1;
            r_in_wr <= 1'b0;
            case (r_in_state)
                IN_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_in_data  <= w_grant[0] ? a_data : b_data;
                        r_in_wr    <= 1'b1;
                        r_in_state <= IN_WR;
                    end
                end
                default: r_in_state <= IN_IDLE;
            endcase
        end
    end

    assign o_valid    = r_o_valid;
    assign o_data     = r_o_data;
    assign cpu_out_rd = r_out_rd;

    // The pop strobe accompanies only the first HOLD cycle; GAP keeps empty from being re-sampled right after a pop.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_o_state <= O_IDLE;
            r_o_valid <= 1'b0;
            r_o_data  <= '0;
            r_out_rd  <= 1'b0;
        end else begin
            r_out_rd <= 1'b0;
            case (r_o_state)
                O_IDLE: begin
                    if (!cpu_out_empty) begin
                        r_o_data  <= cpu_out_data;
                        r_o_valid <= 1'b1;
                        r_out_rd  <= 1'b1;
                        r_o_state <= O_HOLD;
                    end
                end
                O_HOLD: begin
                    if (r_o_valid && o_ready) begin
                        r_o_valid <= 1'b0;
                        r_o_state <= O_GAP;
                    end
                end
                O_GAP:   r_o_state <= O_IDLE;
                default: r_o_state <= O_IDLE;
            endcase
        end
    end

    assign w_step_edge  = r_req_d1 && !r_req_d2;
    assign cpu_debug    = r_debug;
    assign cpu_nxtInstr = r_nxt;

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            r_debug  <= 1'b0;
            r_req_d1 <= 1'b0;
            r_req_d2 <= 1'b0;
            r_nxt    <= 1'b0;
        end else begin
            r_debug  <= step_mode;
            r_req_d1 <= step_req;
            r_req_d2 <= r_req_d1;
            r_nxt    <= w_step_edge && step_mode;
        end
    end

endmodule

// File: tb/tb_hrm_io_ctrl.sv
// Directed bench for hrm_io_ctrl: INBOX arbitration/backpressure, OUTBOX pacing, single-step and reset.
module tb_hrm_io_ctrl;

    localparam int DW = 8;

    logic          clk;
    logic          i_rst;
    logic          a_valid, b_valid, a_ready, b_ready;
    logic [DW-1:0] a_data, b_data;
    logic [DW-1:0] cpu_in_data;
    logic          cpu_in_wr, cpu_in_full;
    logic [DW-1:0] cpu_out_data;
    logic          cpu_out_empty, cpu_out_rd;
    logic          o_valid, o_ready;
    logic [DW-1:0] o_data;
    logic          step_mode, step_req, cpu_debug, cpu_nxtInstr;

    int vectors     = 0;
    int miscompares = 0;

    // Simple OUTBOX FIFO model on the CPU side plus logs of what crossed each interface.
    logic [DW-1:0] ob [0:3];
    logic [2:0]    ob_head = '0;
    logic [2:0]    ob_count;
    int            wr_n  = 0;
    int            pop_n = 0;
    int            acc_n = 0;
    logic [DW-1:0] acc_log [0:7];

    assign cpu_out_data  = ob[ob_head[1:0]];
    assign cpu_out_empty = (ob_head == ob_count);

    hrm_io_ctrl #(.DW(DW)) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .a_valid       (a_valid),
        .a_data        (a_data),
        .a_ready       (a_ready),
        .b_valid       (b_valid),
        .b_data        (b_data),
        .b_ready       (b_ready),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_wr     (cpu_in_wr),
        .cpu_in_full   (cpu_in_full),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_empty (cpu_out_empty),
        .cpu_out_rd    (cpu_out_rd),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_ready       (o_ready),
        .step_mode     (step_mode),
        .step_req      (step_req),
        .cpu_debug     (cpu_debug),
        .cpu_nxtInstr  (cpu_nxtInstr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_in_wr) wr_n <= wr_n + 1;
        if (cpu_out_rd && (ob_head != ob_count)) begin
            ob_head <= ob_head + 3'd1;
            pop_n   <= pop_n + 1;
        end
        if (o_valid && o_ready) begin
            acc_log[acc_n[2:0]] <= o_data;
            acc_n <= acc_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int            snap_wr, snap_pop, pulses;
    logic          exp_wr   [0:7];
    logic [DW-1:0] exp_byte [0:7];

    initial begin
        i_rst = 1'b1;
        a_valid = 1'b0; a_data = '0; b_valid = 1'b0; b_data = '0;
        cpu_in_full = 1'b0; o_ready = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        ob_count = '0;
        ob[0] = 8'h5A; ob[1] = 8'h5B; ob[2] = 8'h6C; ob[3] = 8'h00;
        exp_wr   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_byte = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02};

        // Reset state
        #2 i_rst = 1'b0;
        #1;
        chk("rst_in_wr", cpu_in_wr, 0);
        chk("rst_out_rd", cpu_out_rd, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_in_data", cpu_in_data, 0);
        chk("rst_debug", cpu_debug, 0);
        chk("rst_nxt", cpu_nxtInstr, 0);
        a_valid = 1'b1; a_data = 8'h11;
        tick(); tick();
        chk("rst_a_ready_held", a_ready, 0);
        i_rst = 1'b1;
        #1;
        chk("rel_a_ready_first", a_ready, 0);

        // Single A byte
        tick();
        chk("a11_a_ready", a_ready, 1);
        chk("a11_b_ready", b_ready, 0);
        tick();
        a_valid = 1'b0;
        #1;
        chk("a11_wr", cpu_in_wr, 1);
        chk("a11_data", cpu_in_data, 8'h11);
        chk("a11_ready_in_wr", a_ready, 0);
        tick();
        chk("a11_wr_done", cpu_in_wr, 0);

        // Single B byte: lone requester wins; last grant becomes B
        b_valid = 1'b1; b_data = 8'h22;
        #1;
        chk("b22_b_ready", b_ready, 1);
        chk("b22_a_ready", a_ready, 0);
        tick();
        b_valid = 1'b0;
        #1;
        chk("b22_wr", cpu_in_wr, 1);
        chk("b22_data", cpu_in_data, 8'h22);
        tick();

        // A and B both held valid: alternate, one write every second cycle
        a_valid = 1'b1; a_data = 8'h01; b_valid = 1'b1; b_data = 8'h02;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_wr_%0d", i), cpu_in_wr, exp_wr[i]);
            if (exp_wr[i]) begin
                chk($sformatf("rr_data_%0d", i), cpu_in_data, exp_byte[i]);
            end else begin
                chk($sformatf("rr_ready_%0d", i), {a_ready, b_ready}, (i % 4 == 0) ? 2'b10 : 2'b01);
            end
            if (i == 7) begin
                a_valid = 1'b0; b_valid = 1'b0;
            end
            tick();
        end

        // Full held for 10 cycles with A valid
        snap_wr = wr_n;
        cpu_in_full = 1'b1; a_valid = 1'b1; a_data = 8'h33;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("full_stall_%0d", i), {a_ready, b_ready, cpu_in_wr}, 3'b000);
            tick();
        end
        cpu_in_full = 1'b0;
        #1;
        chk("full_drop_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #1;
        chk("full_drop_wr", cpu_in_wr, 1);
        chk("full_drop_data", cpu_in_data, 8'h33);
        tick(); tick();
        chk("full_write_count", wr_n - snap_wr, 1);

        // OUTBOX: two bytes queued, consumer stalled
        ob_count = 3'd2;
        tick();
        chk("ob_first_rd", cpu_out_rd, 1);
        chk("ob_first_valid", o_valid, 1);
        chk("ob_first_data", o_data, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("ob_hold_%0d", i), {o_valid, cpu_out_rd, o_data}, {2'b10, 8'h5A});
        end
        chk("ob_stall_pops", pop_n, 1);
        o_ready = 1'b1;
        tick();
        chk("ob_gap", {o_valid, cpu_out_rd}, 2'b00);
        tick();
        chk("ob_idle", {o_valid, cpu_out_rd}, 2'b00);
        tick();
        chk("ob_second_rd", cpu_out_rd, 1);
        chk("ob_second_data", o_data, 8'h5B);
        chk("ob_second_valid", o_valid, 1);
        tick(); tick(); tick();
        chk("ob_acc_count", acc_n, 2);
        chk("ob_acc0", acc_log[0], 8'h5A);
        chk("ob_acc1", acc_log[1], 8'h5B);
        chk("ob_pop_total", pop_n, 2);

        // Single-step: one pulse for a held request in step mode
        step_mode = 1'b1;
        #1;
        chk("dbg_latency", cpu_debug, 0);
        tick();
        chk("dbg_on", cpu_debug, 1);
        step_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_nxtInstr) pulses++;
        end
        chk("step_pulses_mode1", pulses, 1);
        step_req = 1'b0;
        tick(); tick(); tick();
        step_mode = 1'b0;
        tick();
        chk("dbg_off", cpu_debug, 0);
        step_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_nxtInstr) pulses++;
        end
        chk("step_pulses_mode0", pulses, 0);
        step_req = 1'b0;
        tick();

        // Reset during IN_WR and O_HOLD
        o_ready = 1'b0; ob_count = 3'd3;
        a_valid = 1'b1; a_data = 8'h44; step_mode = 1'b1;
        #1;
        chk("mid_a_ready", a_ready, 1);
        tick();
        a_valid = 1'b0;
        #1;
        chk("mid_in_wr", cpu_in_wr, 1);
        chk("mid_out_rd", cpu_out_rd, 1);
        chk("mid_debug", cpu_debug, 1);
        snap_wr = wr_n; snap_pop = pop_n;
        i_rst = 1'b0; step_mode = 1'b0;
        #1;
        chk("mid_rst_outputs",
            {cpu_in_wr, cpu_out_rd, o_valid, cpu_debug, cpu_nxtInstr, a_ready, b_ready}, 7'b0);
        chk("mid_rst_o_data", o_data, 0);
        chk("mid_rst_in_data", cpu_in_data, 0);
        a_valid = 1'b1; a_data = 8'h55; b_valid = 1'b1; b_data = 8'h66;
        tick(); tick();
        chk("mid_rst_hold_ready", {a_ready, b_ready}, 2'b00);
        chk("mid_rst_no_write", wr_n - snap_wr, 0);
        chk("mid_rst_no_pop", pop_n - snap_pop, 0);
        i_rst = 1'b1;
        #1;
        chk("mid_rel_first", {a_ready, b_ready, cpu_in_wr, cpu_out_rd}, 4'b0000);
        tick();
        chk("mid_rel_grant_a", {a_ready, b_ready}, 2'b10);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        #1;
        chk("mid_rel_wr", cpu_in_wr, 1);
        chk("mid_rel_data", cpu_in_data, 8'h55);
        tick(); tick();
        chk("mid_rel_write_count", wr_n - snap_wr, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
